// File: rtl/btn_debounce_pkg.sv
// ============================================================================
// btn_debounce_pkg : shared state encoding for the button debounce channels
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_debounce_pkg;

  localparam int NB_STATE = 2;

  typedef enum logic [NB_STATE-1:0] {
    S_RELEASED     = 2'b00,
    S_PRESS_WAIT   = 2'b01,
    S_PRESSED      = 2'b10,
    S_RELEASE_WAIT = 2'b11
  } state_t;

endpackage : btn_debounce_pkg

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// btn_debounce_ch : one button channel - 2-FF sync, counter filter, press pulse
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_pulse,
  output logic o_btn_level
);

  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] c_cnt_last = NB_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_CNT-1:0] c_cnt_one  = NB_CNT'(1);

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  state_t            w_state_next;
  logic [NB_CNT-1:0] r_cnt;
  logic [NB_CNT-1:0] w_cnt_next;
  logic              w_pulse_next;
  logic              w_level_next;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= S_RELEASED;
      r_cnt       <= '0;
      o_btn_pulse <= 1'b0;
      o_btn_level <= 1'b0;
    end else begin
      r_sync1     <= i_btn;
      r_sync2     <= r_sync1;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      o_btn_pulse <= w_pulse_next;
      o_btn_level <= w_level_next;
    end
  end

  // The counter is cleared on every exit from a wait state, so any bounce
  // restarts the qualification window and the count can never wrap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_pulse_next = 1'b0;
    case (r_state)
      S_RELEASED: begin
        if (r_sync2) begin
          w_state_next = S_PRESS_WAIT;
          w_cnt_next   = c_cnt_one;
        end
      end
      S_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_next = S_RELEASED;
        end else if (r_cnt == c_cnt_last) begin
          w_state_next = S_PRESSED;
          w_pulse_next = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      S_PRESSED: begin
        if (!r_sync2) begin
          w_state_next = S_RELEASE_WAIT;
          w_cnt_next   = c_cnt_one;
        end
      end
      S_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_next = S_PRESSED;
        end else if (r_cnt == c_cnt_last) begin
          w_state_next = S_RELEASED;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_next = S_RELEASED;
      end
    endcase
    w_level_next = (w_state_next == S_PRESSED) || (w_state_next == S_RELEASE_WAIT);
  end

endmodule : btn_debounce_ch

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : NB_BTN independent debounced channels feeding the ALU loads
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);

  for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_btn      (i_btn[gi]),
      .o_btn_pulse(o_btn_pulse[gi]),
      .o_btn_level(o_btn_level[gi])
    );
  end

endmodule : btn_debounce

`default_nettype wire
